// File: rtl/car_lanes.sv
// car_lanes: a row of independent cars that step left or right once per
// movement tick, wrapping around a fixed position modulus.
module car_lanes #(
  parameter int unsigned               NUM_CARS   = 8,
  parameter int unsigned               X_W        = 10,
  parameter int unsigned               TICK_DIV   = 2500000,
  parameter int unsigned               WRAP       = 672,
  parameter logic [NUM_CARS*X_W-1:0]   INIT_X     = '0,
  parameter logic [NUM_CARS*4-1:0]     BASE_SPEED = {NUM_CARS{4'd1}},
  parameter logic [NUM_CARS-1:0]       DIR_LEFT   = NUM_CARS'(8'b10101010)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        enable,
  input  logic                        restart,
  input  logic [1:0]                  level,
  output logic [NUM_CARS*X_W-1:0]     car_x,
  output logic                        tick
);

  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W = 6;
  localparam int unsigned SUM_W  = X_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SUM_W-1:0] WRAP_S   = SUM_W'(WRAP);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_CARS*X_W-1:0]   car_q, car_d;
  logic [NUM_CARS*X_W-1:0]   car_move;
  logic                      tick_q, tick_d;
  logic                      update;
  logic [STEP_W-1:0]         mult;

  // Update fires on the last enabled divider cycle
  assign update = enable && (cnt_q == CNT_LAST);
  assign mult   = STEP_W'(level) + STEP_W'(1);

  // Per-car candidate position for the coming update edge
  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    logic [X_W-1:0]    x;
    logic [STEP_W-1:0] step;
    logic [SUM_W-1:0]  fwd;
    logic [SUM_W-1:0]  back;
    logic [X_W-1:0]    nxt;

    // Wrap-around step in either direction using an X_W+1 bit intermediate
    always_comb begin
      x    = car_q[g*X_W +: X_W];
      step = STEP_W'(BASE_SPEED[g*4 +: 4]) * mult;
      fwd  = SUM_W'(x) + SUM_W'(step);
      back = SUM_W'(x) + WRAP_S - SUM_W'(step);
      nxt  = x;
      if (DIR_LEFT[g]) begin
        if (SUM_W'(x) >= SUM_W'(step)) nxt = X_W'(SUM_W'(x) - SUM_W'(step));
        else                           nxt = X_W'(back);
      end else begin
        if (fwd >= WRAP_S) nxt = X_W'(fwd - WRAP_S);
        else               nxt = X_W'(fwd);
      end
    end

    assign car_move[g*X_W +: X_W] = nxt;
  end

  // Next state: restart dominates, otherwise count and move on the last count
  always_comb begin
    cnt_d  = cnt_q;
    car_d  = car_q;
    tick_d = 1'b0;
    if (restart) begin
      car_d = INIT_X;
      cnt_d = '0;
    end else if (update) begin
      cnt_d  = '0;
      car_d  = car_move;
      tick_d = 1'b1;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset to the start positions
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      car_q  <= INIT_X;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      car_q  <= car_d;
      tick_q <= tick_d;
    end
  end

  assign car_x = car_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_car_lanes.sv
// Bench for car_lanes: table-driven cycle vectors plus reset and random runs.
module tb_car_lanes;

  localparam int W = 672;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        restart;
  logic [1:0]  level;
  logic [19:0] car_x;
  logic        tick;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic       rs;
    logic [1:0] lv;
    int         c0;
    int         c1;
    logic       t;
  } vec_t;

  vec_t vecs[$];

  car_lanes #(
    .NUM_CARS  (2),
    .X_W       (10),
    .TICK_DIV  (4),
    .WRAP      (672),
    .INIT_X    ({10'd1, 10'd670}),
    .BASE_SPEED({4'd3, 4'd2}),
    .DIR_LEFT  (2'b10)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .enable (enable),
    .restart(restart),
    .level  (level),
    .car_x  (car_x),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  function automatic int car0();
    return int'(car_x[9:0]);
  endfunction

  function automatic int car1();
    return int'(car_x[19:10]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input int e0, input int e1, input int et);
    check({name, ".car0"}, car0(), e0);
    check({name, ".car1"}, car1(), e1);
    check({name, ".tick"}, int'(tick), et);
  endtask

  // Drive inputs at the falling edge, sample 1 time unit after the rising edge
  task automatic step_cycle(input logic en, input logic rs, input logic [1:0] lv);
    @(negedge clk);
    enable  = en;
    restart = rs;
    level   = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic rs, input logic [1:0] lv,
                     input int c0, input int c1, input logic t, input int n);
    vec_t v;
    v.en = en; v.rs = rs; v.lv = lv; v.c0 = c0; v.c1 = c1; v.t = t;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int m0, m1, lv, s0, s1, e0, e1;

    clk = 1'b0; rst = 1'b1; enable = 1'b0; restart = 1'b0; level = 2'd0;

    // Expected state after each clocked vector
    add(1, 0, 0, 670,   1, 0, 3);
    add(1, 0, 0,   0, 670, 1, 1);   // 670+2 wraps to 0, 1-3 wraps to 670
    add(1, 0, 0,   0, 670, 0, 3);
    add(1, 0, 3,   8, 658, 1, 1);   // level sampled only at update
    add(1, 0, 3,   8, 658, 0, 3);
    add(1, 0, 3,  16, 646, 1, 1);
    add(1, 0, 3,  16, 646, 0, 3);
    add(1, 0, 3,  24, 634, 1, 1);
    add(1, 0, 3,  24, 634, 0, 2);   // two counted cycles
    add(0, 0, 3,  24, 634, 0, 10);  // paused
    add(1, 0, 0,  24, 634, 0, 1);
    add(1, 0, 1,  28, 628, 1, 1);   // update 2 enabled cycles after resume
    add(0, 0, 0,  28, 628, 0, 1);
    add(1, 0, 2,  28, 628, 0, 3);
    add(1, 1, 2, 670,   1, 0, 1);   // restart on update edge wins
    add(1, 0, 0, 670,   1, 0, 3);
    add(1, 0, 2,   4, 664, 1, 1);   // 4 cycles after restart
    add(0, 1, 0, 670,   1, 0, 1);   // restart while disabled
    add(0, 0, 0, 670,   1, 0, 1);

    // Asynchronous reset is visible before any clock edge
    #2;
    check_state("rst_async", 670, 1, 0);
    @(posedge clk); #1;
    check_state("rst_hold", 670, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step_cycle(vecs[i].en, vecs[i].rs, vecs[i].lv);
      check_state($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, int'(vecs[i].t));
    end

    // Reset between edges mid-count
    for (int i = 0; i < 4; i++) step_cycle(1, 0, 0);
    check_state("pre_rst_upd", 0, 670, 1);
    step_cycle(1, 0, 0);
    step_cycle(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_state("rst_midcount", 670, 1, 0);
    @(posedge clk); #1;
    check_state("rst_held_enabled", 670, 1, 0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;

    // First update TICK_DIV enabled cycles after reset release
    for (int i = 0; i < 3; i++) begin
      step_cycle(1, 0, 0);
      check_state($sformatf("post_rst%0d", i), 670, 1, 0);
    end
    step_cycle(1, 0, 0);
    check_state("post_rst_upd", 0, 670, 1);

    // Reset during the tick cycle clears tick immediately
    #2 rst = 1'b1;
    #1;
    check_state("rst_in_tick", 670, 1, 0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;

    // Random levels and pauses against a modular reference model
    step_cycle(0, 1, 0);
    m0 = 670; m1 = 1;
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) step_cycle(0, 0, 2'($urandom_range(0, 3)));
        step_cycle(1, 0, 2'($urandom_range(0, 3)));
      end
      lv = int'($urandom_range(0, 3));
      step_cycle(1, 0, 2'(lv));
      s0 = 2 * (lv + 1);
      s1 = 3 * (lv + 1);
      m0 = (m0 + s0) % W;
      m1 = (m1 + W - s1) % W;
      e0 = m0; e1 = m1;
      check_state($sformatf("rnd%0d", t), e0, e1, 1);
      check($sformatf("rnd%0d.range", t), int'(car0() < W && car1() < W), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
